// File: rtl/sysarr_ctrl.sv
// sysarr_ctrl: loads a weight tile into the systolic array, then streams skewed activation vectors and drains.
module sysarr_ctrl #(
    parameter int width_height = 4,
    parameter int ADDR_W       = 8,
    parameter int CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        cfg_wload,
    input  logic [ADDR_W-1:0]           cfg_wbase,
    input  logic [ADDR_W-1:0]           cfg_dbase,
    input  logic [CNT_W-1:0]            cfg_nvec,
    output logic                        w_ren,
    output logic [ADDR_W-1:0]           w_raddr,
    input  logic [16*width_height-1:0]  w_rdata,
    output logic                        d_ren,
    output logic [ADDR_W-1:0]           d_raddr,
    input  logic [8*width_height-1:0]   d_rdata,
    output logic [16*width_height-1:0]  win,
    output logic [width_height-1:0]     wwrite,
    output logic [8*width_height-1:0]   datain,
    output logic                        active,
    output logic                        busy,
    output logic                        done
);
    localparam int N  = width_height;
    localparam int CW = CNT_W + $clog2(N) + 2;

    typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t            state, nxt;
    logic [CW-1:0]     cnt, stream_last;
    logic [ADDR_W-1:0] wbase_q, dbase_q;
    logic [CNT_W-1:0]  nvec_q;
    logic              wr_q, dv;
    logic [8*N-1:0]    vreg;

    assign stream_last = CW'(nvec_q) + CW'(N);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = cfg_wload ? WLOAD : (cfg_nvec != '0) ? STREAM : DONE;
            WLOAD:   if (cnt == CW'(N)) nxt = (nvec_q != '0) ? STREAM : DONE;
            STREAM:  if (cnt == stream_last) nxt = DRAIN;
            DRAIN:   if (cnt == CW'(2*N-1)) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // Highest weight row is fetched first so that row wbase lands in array row 0.
    assign w_ren   = state == WLOAD && cnt < CW'(N);
    assign w_raddr = w_ren ? wbase_q + ADDR_W'(N-1) - ADDR_W'(cnt) : '0;
    assign d_ren   = state == STREAM && cnt < CW'(nvec_q);
    assign d_raddr = d_ren ? dbase_q + ADDR_W'(cnt) : '0;
    assign active  = state == STREAM && cnt >= CW'(2) && cnt <= stream_last;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign wwrite  = {N{wr_q}};
    assign win     = wr_q ? w_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wbase_q <= '0;
            dbase_q <= '0;
            nvec_q  <= '0;
            wr_q    <= 1'b0;
            dv      <= 1'b0;
            vreg    <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + CW'(1);
            if (state == IDLE && start) begin
                wbase_q <= cfg_wbase;
                dbase_q <= cfg_dbase;
                nvec_q  <= cfg_nvec;
            end
            wr_q <= w_ren;
            dv   <= d_ren;
            vreg <= dv ? d_rdata : '0;
        end
    end

    assign datain[7:0] = vreg[7:0];

    // Lane i gets i extra register stages to form the diagonal input wavefront.
    for (genvar i = 1; i < N; i++) begin : g_skew
        logic [8*i-1:0] sr;
        if (i == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) sr <= '0;
                else sr <= vreg[8*i +: 8];
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) sr <= '0;
                else sr <= {sr[8*i-9:0], vreg[8*i +: 8]};
        end
        assign datain[8*i +: 8] = sr[8*i-1 -: 8];
    end
endmodule
